// File: rtl/async_fifo_burst_reader_pkg.sv
// Shared types and default widths for the async FIFO read-side burst drain stage.
package async_fifo_burst_reader_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 32;
  localparam int unsigned FIFO_DEPTH      = 16;
  localparam int unsigned FIFO_ADDR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned BURST_LEN_DEF   = 4;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/async_fifo_burst_reader_if.sv
// FIFO read port plus output stream and status of the burst reader.
interface async_fifo_burst_reader_if
  import async_fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned CNT_W      = CNT_W_DEF
);
  logic                  enable;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [CNT_W-1:0]      words_out;
  logic                  busy;

  modport master (
    input  enable, fifo_empty, fifo_rdata, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last, words_out, busy
  );

  modport slave (
    output enable, fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last, words_out, busy
  );
endinterface

// File: rtl/burst_reader_skid.sv
// Two-entry in-order output buffer; head entry drives the stream directly from flops.
module burst_reader_skid #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_r,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [1:0]            occ_o
);

  logic                  head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic                  head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic                  do_pop_c;

  // Pushes never arrive when full without a pop: read issue reserves the slot.
  always_comb begin
    head_vld_d  = head_vld_q;
    tail_vld_d  = tail_vld_q;
    head_last_d = head_last_q;
    tail_last_d = tail_last_q;
    head_d      = head_q;
    tail_d      = tail_q;
    do_pop_c    = pop_i && head_vld_q;
    if (do_pop_c) begin
      if (tail_vld_q) begin
        head_d      = tail_q;
        head_last_d = tail_last_q;
        if (push_i) begin
          tail_d      = push_data_i;
          tail_last_d = push_last_i;
        end else begin
          tail_vld_d = 1'b0;
        end
      end else if (push_i) begin
        head_d      = push_data_i;
        head_last_d = push_last_i;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (push_i) begin
      if (!head_vld_q) begin
        head_d      = push_data_i;
        head_last_d = push_last_i;
        head_vld_d  = 1'b1;
      end else begin
        tail_d      = push_data_i;
        tail_last_d = push_last_i;
        tail_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_r or negedge rst) begin
    if (!rst) begin
      head_vld_q  <= 1'b0;
      tail_vld_q  <= 1'b0;
      head_last_q <= 1'b0;
      tail_last_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      head_vld_q  <= head_vld_d;
      tail_vld_q  <= tail_vld_d;
      head_last_q <= head_last_d;
      tail_last_q <= tail_last_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  assign valid_o = head_vld_q;
  assign data_o  = head_q;
  assign last_o  = head_last_q;
  assign occ_o   = {head_vld_q & tail_vld_q, head_vld_q ^ tail_vld_q};

endmodule

// File: rtl/async_fifo_burst_reader.sv
// Drains the async FIFO read port into a valid/ready stream framed into fixed-length bursts.
module async_fifo_burst_reader
  import async_fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                       clk_r,
  input  logic                       rst,
  async_fifo_burst_reader_if.master  bus
);

  localparam int unsigned BW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    fetch_cnt_q, fetch_cnt_d, cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             inflight_q, busy_q, busy_d;
  logic             rd_en_c, pop_c, fetch_wrap_c;
  logic [2:0]       fill_c, occ_next_c;
  logic             sk_valid, sk_last;
  logic [1:0]       sk_occ;
  logic [DATA_WIDTH-1:0] sk_data;

  assign pop_c        = sk_valid && bus.m_ready;
  assign fill_c       = 3'(sk_occ) + 3'(inflight_q);
  assign fetch_wrap_c = rd_en_c && (fetch_cnt_q == LAST_IDX);

  always_ff @(posedge clk_r or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.enable) state_d = ST_RUN;
      ST_RUN:    if (!bus.enable) state_d = (fetch_cnt_q == '0) ? ST_IDLE : ST_FINISH;
      ST_FINISH: begin
        if (bus.enable)        state_d = ST_RUN;
        else if (fetch_wrap_c) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Issue a read only if the word it returns is guaranteed a buffer slot.
  always_comb begin
    rd_en_c = 1'b0;
    if ((state_q != ST_IDLE) && !bus.fifo_empty && (fill_c < (3'd2 + 3'(pop_c))))
      rd_en_c = 1'b1;
  end

  // cap_cnt tracks the burst position of each captured word; capture order equals accept order.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    if (rd_en_c)
      fetch_cnt_d = (fetch_cnt_q == LAST_IDX) ? '0 : fetch_cnt_q + BW'(1);
    if (inflight_q)
      cap_cnt_d = (cap_cnt_q == LAST_IDX) ? '0 : cap_cnt_q + BW'(1);
    words_d    = words_q + CNT_W'(pop_c);
    occ_next_c = fill_c - 3'(pop_c);
    busy_d     = (state_d != ST_IDLE) || (occ_next_c != 3'd0) || rd_en_c;
  end

  always_ff @(posedge clk_r or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      cap_cnt_q   <= '0;
      words_q     <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      words_q     <= words_d;
      inflight_q  <= rd_en_c;
      busy_q      <= busy_d;
    end
  end

  burst_reader_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk_r       (clk_r),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (bus.fifo_rdata),
    .push_last_i (cap_cnt_q == LAST_IDX),
    .pop_i       (bus.m_ready),
    .valid_o     (sk_valid),
    .data_o      (sk_data),
    .last_o      (sk_last),
    .occ_o       (sk_occ)
  );

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.m_valid    = sk_valid;
  assign bus.m_data     = sk_data;
  assign bus.m_last     = sk_last;
  assign bus.words_out  = words_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_async_fifo_burst_reader.sv
// Bench for async_fifo_burst_reader: FIFO model, scoreboard queue, scenario table and corner sequences.
module tb_async_fifo_burst_reader;

  typedef struct {
    int n;
    int mode;      // 0: ready held high, 1: random ready, 2: alternating ready
    int exp_last;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  async_fifo_burst_reader_if #(.DATA_WIDTH(32), .CNT_W(8)) bus ();

  async_fifo_burst_reader #(.DATA_WIDTH(32), .BURST_LEN(4), .CNT_W(8)) dut (
    .clk_r (clk),
    .rst   (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];
  int pushed_n = 0;
  int popped_n = 0;
  int push_idx = 0;
  exp_t exp_q[$];

  int hs_n = 0;
  int last_n = 0;
  int rd_n = 0;
  logic rd_seen = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  assign bus.fifo_empty = (pushed_n == popped_n);
  initial bus.fifo_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_t e;
    mem[pushed_n] = w;
    e.data = w;
    e.last = ((push_idx % 4) == 3);
    exp_q.push_back(e);
    push_idx++;
    pushed_n++;
  endtask

  // FIFO model: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    if (rd_seen) begin
      if (popped_n == pushed_n) chk("rd_on_empty", 1, 0);
      bus.fifo_rdata <= mem[popped_n];
      popped_n <= popped_n + 1;
    end
  end

  // Stream monitor and scoreboard
  always @(negedge clk) begin
    exp_t e;
    rd_seen = bus.fifo_rd_en;
    if (bus.fifo_rd_en) rd_n++;
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, prev_data);
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("words_out_run", bus.words_out, 64'(hs_n[7:0]));
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", bus.m_data, e.data);
          chk("m_last", bus.m_last, e.last);
        end
        hs_n++;
        if (bus.m_last) last_n++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic wait_hs(input int target, input int limit);
    int k;
    k = 0;
    while ((hs_n < target) && (k < limit)) begin
      @(negedge clk); #1;
      k++;
    end
    chk("hs_timeout", (hs_n >= target), 1);
  endtask

  task automatic run_scn(input int n, input int mode, input int exp_last);
    int base_hs, base_last, first_c, last_c, c, prev;
    base_hs = hs_n; base_last = last_n;
    first_c = -1; last_c = -1; c = 0; prev = hs_n;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) push_word($urandom);
    bus.m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    while ((hs_n - base_hs < n) && (c < n * 10 + 40)) begin
      @(negedge clk); #1;
      if (hs_n != prev) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        prev = hs_n;
      end
      c++;
      @(posedge clk); #1;
      if (mode == 1) bus.m_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) bus.m_ready = ~bus.m_ready;
    end
    bus.m_ready = 1'b1;
    chk("scn_delivered", hs_n - base_hs, n);
    chk("scn_lasts", last_n - base_last, exp_last);
    if (mode == 0) chk("scn_gapless_span", last_c - first_c + 1, n);
    @(negedge clk); #1;
    chk("scn_words_out", bus.words_out, 64'(hs_n[7:0]));
  endtask

  initial begin
    vec_t tbl[4];
    int base_rd, base_hs, base_last;
    logic [31:0] first_w;
    tbl[0] = '{n: 8,  mode: 0, exp_last: 2};
    tbl[1] = '{n: 12, mode: 1, exp_last: 3};
    tbl[2] = '{n: 4,  mode: 2, exp_last: 1};
    tbl[3] = '{n: 16, mode: 1, exp_last: 4};

    // Reset with FIFO non-empty and enable high
    bus.enable = 1'b1;
    bus.m_ready = 1'b1;
    push_word(32'hA5A5A5A5);
    push_word(32'hB784C3A8);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_words_out", bus.words_out, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    #1 chk("idle_rd_en", bus.fifo_rd_en, 0);
    @(negedge clk); #1;
    chk("first_rd_en", bus.fifo_rd_en, 1);
    @(negedge clk); #1;
    chk("second_rd_en", bus.fifo_rd_en, 1);
    @(negedge clk); #1;
    chk("lat_m_valid", bus.m_valid, 1);
    chk("lat_m_data", bus.m_data, 32'hA5A5A5A5);
    @(negedge clk); #1;
    chk("basic_m_data2", bus.m_data, 32'hB784C3A8);
    @(negedge clk); #1;
    chk("basic_words_out", bus.words_out, 2);
    chk("basic_rd_n", rd_n, 2);

    // Backpressure: only two reads while stalled, then gapless release
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    base_rd = rd_n;
    first_w = $urandom;
    push_word(first_w);
    for (int i = 1; i < 8; i++) push_word($urandom);
    repeat (10) @(negedge clk);
    #1;
    chk("bp_reads", rd_n - base_rd, 2);
    chk("bp_valid", bus.m_valid, 1);
    chk("bp_head", bus.m_data, first_w);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    base_hs = hs_n;
    repeat (8) @(negedge clk);
    #1;
    chk("bp_gapless", hs_n - base_hs, 8);

    // Realign to a burst boundary, then table of stream scenarios
    run_scn(2, 0, 1);
    foreach (tbl[i]) run_scn(tbl[i].n, tbl[i].mode, tbl[i].exp_last);

    // Enable drop after the second read of a burst
    base_rd = rd_n; base_hs = hs_n; base_last = last_n;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push_word($urandom);
    for (int k = 0; (k < 20) && (rd_n - base_rd < 2); k++) begin
      @(negedge clk); #1;
    end
    chk("drop_two_reads", rd_n - base_rd, 2);
    @(posedge clk); #1;
    bus.enable = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("drop_reads", rd_n - base_rd, 4);
    chk("drop_left_in_fifo", pushed_n - popped_n, 2);
    chk("drop_delivered", hs_n - base_hs, 4);
    chk("drop_lasts", last_n - base_last, 1);
    chk("drop_busy", bus.busy, 0);
    @(posedge clk); #1;
    bus.enable = 1'b1;
    wait_hs(base_hs + 6, 40);

    // FIFO runs dry mid-burst; state stays active and framing continues
    base_rd = rd_n;
    repeat (6) @(negedge clk);
    #1;
    chk("empty_no_rd", rd_n - base_rd, 0);
    chk("empty_busy", bus.busy, 1);
    run_scn(2, 0, 1);

    // Counter wrap at 256 accepted words
    run_scn(196, 0, 49);
    chk("wrap_words_out", bus.words_out, 0);
    chk("wrap_total_hs", hs_n, 256);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/async_fifo_burst_reader.md
# async_fifo_burst_reader

Read-side drain stage in the `clk_r` domain, directly downstream of `asynchronous_fifo`. It pops words from the FIFO whenever space allows and presents them on a valid/ready stream through a 2-entry output buffer. It frames the stream into fixed-length bursts with `m_last`, and an `enable` input stops reading only at burst boundaries. No word is lost or duplicated under any backpressure pattern.

## Interface
- `DATA_WIDTH`, 32, FIFO word and stream data width
- `BURST_LEN`, 4, words per burst (≥2); `m_last` marks the final word of each burst
- `CNT_W`, 8, width of the delivered-word counter `words_out`

- `clk_r` in 1: read-domain clock; the block's only clock
- `rst` in 1: asynchronous, active-low reset
- `enable` in 1: request to run; a deassertion takes effect at the next burst boundary
- `fifo_empty` in 1: FIFO empty flag, valid in the current `clk_r` cycle
- `fifo_rdata` in DATA_WIDTH: FIFO `buff_out`, valid the cycle after `fifo_rd_en`
- `fifo_rd_en` out 1: FIFO pop strobe
- `m_valid` out 1: output word valid
- `m_ready` in 1: downstream accept
- `m_data` out DATA_WIDTH: output word
- `m_last` out 1: last word of the burst, qualified by `m_valid`
- `words_out` out CNT_W: count of accepted words (`m_valid && m_ready`); wraps modulo 2^CNT_W
- `busy` out 1: high whenever the state is not IDLE, or `occ` ≠ 0, or `inflight` ≠ 0

## Operation
- **State machine:** IDLE, RUN, FINISH.
  - IDLE → RUN when `enable` = 1.
  - RUN → IDLE when `enable` = 0 and `fetch_cnt` = 0.
  - RUN → FINISH when `enable` = 0 and `fetch_cnt` ≠ 0.
  - FINISH → IDLE when the read that completes the burst is issued (`fetch_cnt` wraps to 0).
  - In FINISH, `enable` = 1 returns to RUN.
- **`fetch_cnt`:** counts reads issued, modulo BURST_LEN.
- **`beat_cnt`:** counts accepted words, modulo BURST_LEN.
- **`m_last`:** equals (`beat_cnt` = BURST_LEN−1) for the head word.
- **`occ`:** output buffer occupancy, 0..2.
- **`inflight`:** 1 in the cycle after `fifo_rd_en` was asserted, otherwise 0.
- **Read issue:** `fifo_rd_en` = (state ∈ {RUN, FINISH}) && !`fifo_empty` && (`occ` + `inflight` − pop < 2), where pop = `m_valid && m_ready`. This sustains 1 word/cycle with `m_ready` held high.
- **Capture:** when `inflight` = 1, `fifo_rdata` is written to the buffer tail. Capture and pop in the same cycle keep `occ` unchanged.
- **Stream:** `m_data` and `m_last` come from the buffer head. While `m_valid` = 1 and `m_ready` = 0, `m_valid`, `m_data` and `m_last` hold stable.
- **FIFO empty:** in RUN or FINISH, no read is issued and the state is held; reading resumes when data arrives, and burst framing is unaffected.
- **Leaving RUN/FINISH:** the output buffer keeps draining after the transition to IDLE.
- **Reset:** asserting `rst` at any time clears the state to IDLE and clears all counters, `occ` and `inflight`. Buffered and in-flight words are discarded. The FIFO and this block share the reset.
- **Reset values:** all outputs are 0.

## Timing
- `fifo_rd_en` is asserted in cycle t; `fifo_rdata` is captured at the end of t+1; `m_valid` is first high in cycle t+2.
- IDLE → RUN takes one cycle, so the first `fifo_rd_en` is possible in the cycle after `enable` is sampled high.
- `fifo_rd_en` has a combinational path from `m_ready`. All other outputs are registered.
- `words_out` updates on the edge that completes the handshake.

## Structure
- The state encoding (IDLE/RUN/FINISH) and the default widths go in a shared package/header alongside the FIFO's parameters.
- One sub-module: `burst_reader_skid`, the 2-entry buffer. It has push, pop, head data/last and `occ`.
- Counters, FSM and read-issue logic live in the top level.

## Test plan
- **Reset:** `rst` = 0 with `fifo_empty` = 0 and `enable` = 1 → `fifo_rd_en`, `m_valid`, `m_last`, `words_out` and `busy` are all 0. After release, the first `fifo_rd_en` comes one cycle after `enable` is sampled high.
- **Basic read:** FIFO model holds A5A5A5A5 then B784C3A8; `m_ready` = 1 → two consecutive `fifo_rd_en` pulses; `m_data` = A5A5A5A5 at t+2, then B784C3A8; `words_out` = 2; `m_last` = 0.
- **Backpressure:** 8 words queued, `m_ready` = 0 → exactly 2 reads issued and `m_data` holds the first word stable. Releasing `m_ready` → all 8 words arrive in order with no gaps after the initial 2-cycle latency and no duplicates.
- **Burst framing:** BURST_LEN = 4, 8 words, `m_ready` = 1 → `m_last` is high on words 4 and 8 only; throughput is 1 word/cycle.
- **Enable drop mid-burst:** `enable` drops after the 2nd read with 6 words available → reads continue through word 4, then IDLE; words 5–6 stay in the FIFO; `m_last` is high on word 4.
- **Empty mid-burst and wrap:** the FIFO empties after word 2 → `fifo_rd_en` = 0 and the state stays RUN. Words 3–4 arriving later → `m_last` is high on word 4. With CNT_W = 8, after 256 accepted words `words_out` = 0.
